toy_bpu_tage_base_ctrl: RTL and testbench
=========================================

TOY_BPU_TAGE_BASE_CTRL -- requirements
Module: toy_bpu_tage_base_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default TAGE_BASE_INDEX_WIDTH, base table index width.
REQ-002 SHALL have parameter CTR_W, default TAGE_BASE_PRED_WIDTH, per-entry saturating counter width (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port lkp_vld  input  1  lookup request valid.
REQ-006 SHALL have port lkp_idx  input  INDEX_W  lookup index.
REQ-007 SHALL have port lkp_rdy  output  1  lookup accepted when lkp_vld&lkp_rdy.
REQ-008 SHALL have port lkp_rsp_vld  output  1  lookup response valid.
REQ-009 SHALL have port lkp_rsp_ctr  output  CTR_W  counter value for the lookup.
REQ-010 SHALL have port lkp_rsp_taken  output  1  prediction = MSB of lkp_rsp_ctr.
REQ-011 SHALL have port upd_vld  input  1  training update valid.
REQ-012 SHALL have port upd_idx  input  INDEX_W  update index.
REQ-013 SHALL have port upd_taken  input  1  resolved direction.
REQ-014 SHALL have port upd_rdy  output  1  update accepted when upd_vld&upd_rdy.
REQ-015 SHALL have ports tbl_req_vld/tbl_req_wren (output 1), tbl_req_addr (output INDEX_W), tbl_req_wdata (output CTR_W): single-port base table request, one access per cycle.
REQ-016 SHALL have port tbl_ack_rdata  input  CTR_W  read data, valid the cycle after a read request.
REQ-017 SHALL have port init_done  output  1  table initialisation complete.

Function
REQ-018 SHALL implement states INIT, IDLE, RD_WAIT, WRITE; INIT entered on rst.
REQ-019 In INIT SHALL write WEAK_NT = 2^(CTR_W-1)-1 to addresses 0..2^INDEX_W-1, one per cycle, ascending; last write -> IDLE, init_done=1 next cycle.
REQ-020 In INIT lkp_rdy=0, upd_rdy=0.
REQ-021 Update accept only in IDLE: upd_rdy=1 when IDLE and update wins arbitration; accepted update issues table read (wren=0, addr=upd_idx) that cycle, latches idx/taken, -> RD_WAIT.
REQ-022 RD_WAIT: compute new counter from tbl_ack_rdata: taken -> min(ctr+1, 2^CTR_W-1); not taken -> max(ctr-1, 0); -> WRITE.
REQ-023 WRITE: issue table write of new counter to latched idx; -> IDLE; lkp_rdy=0 this cycle.
REQ-024 Table port priority: INIT write > update WRITE > lookup read > update read.
REQ-025 Starvation guard: 3-bit counter of consecutive IDLE cycles with upd_vld=1 not accepted; at 3, update read wins over lookup (lkp_rdy=0) that cycle; counter clears on update accept.
REQ-026 Lookup accepted -> table read addr=lkp_idx; lkp_rsp_vld=1 exactly next cycle, lkp_rsp_ctr = tbl_ack_rdata; no backpressure on response.
REQ-027 Forwarding: lookup accepted in RD_WAIT with lkp_idx == latched update idx SHALL return the post-update counter (computed in REQ-022), not table data.
REQ-028 lkp_rdy SHALL be 1 in RD_WAIT and IDLE unless blocked by REQ-024/025; simultaneous lookup and update on same index in IDLE: lookup wins, returns pre-update value.
REQ-029 tbl_req_vld=0 when no access; tbl_req_wdata=0 on reads.

Reset
REQ-030 On rst=1 at a clock edge: state=INIT, init address=0, starvation counter=0, in-flight update discarded, next cycle lkp_rsp_vld=0, lkp_rdy=0, upd_rdy=0, init_done=0, tbl_req_vld=0.
REQ-031 Reset asserted mid-INIT or mid-RMW SHALL restart INIT from address 0; no partial write after reset edge.

Verification (INDEX_W=4, CTR_W=2)
REQ-032 Release reset -> 16 writes of 2'b01 to addr 0..15 on consecutive cycles, init_done=1 on 17th cycle, rdy low throughout.
REQ-033 Three updates taken on idx 5 then lookup idx 5 -> ctr 01->10->11->11 (saturate), lookup rsp ctr=2'b11, taken=1, one cycle after accept.
REQ-034 Update not-taken idx 2 at ctr 2'b00 -> write 2'b00 (floor saturation); lookup returns 2'b00, taken=0.
REQ-035 Update idx 7 taken accepted, lookup idx 7 in following (RD_WAIT) cycle -> rsp ctr=2'b10 via forwarding; lookup in WRITE cycle -> lkp_rdy=0.
REQ-036 lkp_vld held high continuously with upd_vld high -> update read issued on 4th cycle (lkp_rdy=0 that cycle), upd_rdy=1 once.
REQ-037 Assert rst during RD_WAIT -> no table write to that idx, INIT restarts at addr 0, lkp_rsp_vld=0 next cycle.

Source files
------------

// File: rtl/toy_bpu_tage_base_ctrl.sv
// TAGE base-table controller: initialises the table, then serves lookups and read-modify-write training updates.
// Lookup response one cycle after accept; each update takes three cycles and blocks new updates until done.
// Lookups and updates share one single-port table; a starvation guard makes a waiting update win every fourth cycle.
module toy_bpu_tage_base_ctrl #(
    parameter int INDEX_W = 4,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lkp_vld,
    input  logic [INDEX_W-1:0] lkp_idx,
    output logic               lkp_rdy,
    output logic               lkp_rsp_vld,
    output logic [CTR_W-1:0]   lkp_rsp_ctr,
    output logic               lkp_rsp_taken,
    input  logic               upd_vld,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken,
    output logic               upd_rdy,
    output logic               tbl_req_vld,
    output logic               tbl_req_wren,
    output logic [INDEX_W-1:0] tbl_req_addr,
    output logic [CTR_W-1:0]   tbl_req_wdata,
    input  logic [CTR_W-1:0]   tbl_ack_rdata,
    output logic               init_done
);
    localparam logic [CTR_W-1:0]   WEAK_NT   = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0]   CTR_MAX   = '1;
    localparam logic [INDEX_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, WRITE} state_t;

    state_t             state;
    logic [INDEX_W-1:0] init_addr;
    logic [INDEX_W-1:0] upd_idx_q;
    logic               upd_taken_q;
    logic [CTR_W-1:0]   new_ctr_q;
    logic [CTR_W-1:0]   new_ctr;
    logic [2:0]         starve_cnt;
    logic               fwd_q;
    logic               starve;
    logic               lkp_fire;
    logic               upd_fire;

    // Rdy is masked while rst is high so nothing is accepted on the reset edge.
    assign starve   = (state == IDLE) && upd_vld && (starve_cnt >= 3'd3);
    assign lkp_rdy  = !rst && ((state == IDLE) || (state == RD_WAIT)) && !starve;
    assign upd_rdy  = !rst && (state == IDLE) && (!lkp_vld || starve);
    assign lkp_fire = lkp_vld && lkp_rdy;
    assign upd_fire = upd_vld && upd_rdy;

    always_comb begin
        new_ctr = tbl_ack_rdata;
        if (upd_taken_q) begin
            if (tbl_ack_rdata != CTR_MAX) new_ctr = tbl_ack_rdata + CTR_W'(1);
        end else begin
            if (tbl_ack_rdata != '0) new_ctr = tbl_ack_rdata - CTR_W'(1);
        end
    end

    always_comb begin
        tbl_req_vld   = 1'b0;
        tbl_req_wren  = 1'b0;
        tbl_req_addr  = '0;
        tbl_req_wdata = '0;
        if (!rst) begin
            if (state == INIT) begin
                tbl_req_vld   = 1'b1;
                tbl_req_wren  = 1'b1;
                tbl_req_addr  = init_addr;
                tbl_req_wdata = WEAK_NT;
            end else if (state == WRITE) begin
                tbl_req_vld   = 1'b1;
                tbl_req_wren  = 1'b1;
                tbl_req_addr  = upd_idx_q;
                tbl_req_wdata = new_ctr_q;
            end else if (lkp_fire) begin
                tbl_req_vld  = 1'b1;
                tbl_req_addr = lkp_idx;
            end else if (upd_fire) begin
                tbl_req_vld  = 1'b1;
                tbl_req_addr = upd_idx;
            end
        end
    end

    // A lookup hitting the in-flight update's index returns the freshly computed counter.
    assign lkp_rsp_ctr   = fwd_q ? new_ctr_q : tbl_ack_rdata;
    assign lkp_rsp_taken = lkp_rsp_ctr[CTR_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_addr   <= '0;
            starve_cnt  <= '0;
            lkp_rsp_vld <= 1'b0;
            init_done   <= 1'b0;
            fwd_q       <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            new_ctr_q   <= '0;
        end else begin
            lkp_rsp_vld <= lkp_fire;
            fwd_q       <= lkp_fire && (state == RD_WAIT) && (lkp_idx == upd_idx_q);
            case (state)
                INIT: begin
                    init_addr <= init_addr + INDEX_W'(1);
                    if (init_addr == ADDR_LAST) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (upd_fire) begin
                        upd_idx_q   <= upd_idx;
                        upd_taken_q <= upd_taken;
                        starve_cnt  <= '0;
                        state       <= RD_WAIT;
                    end else if (upd_vld) begin
                        if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    new_ctr_q <= new_ctr;
                    state     <= WRITE;
                end
                WRITE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_toy_bpu_tage_base_ctrl.sv
// Bench for toy_bpu_tage_base_ctrl: owns the single-port table memory and a per-index counter model.
module tb_toy_bpu_tage_base_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       lkp_vld, lkp_rdy, lkp_rsp_vld, lkp_rsp_taken;
    logic [3:0] lkp_idx;
    logic [1:0] lkp_rsp_ctr;
    logic       upd_vld, upd_taken, upd_rdy;
    logic [3:0] upd_idx;
    logic       tbl_req_vld, tbl_req_wren;
    logic [3:0] tbl_req_addr;
    logic [1:0] tbl_req_wdata;
    logic [1:0] tbl_ack_rdata;
    logic       init_done;

    logic [1:0] mem [16];
    logic       poke_en = 1'b0;
    logic [3:0] poke_idx = '0;
    logic [1:0] poke_val = '0;

    int total = 0;
    int bad   = 0;
    int model [16];
    bit mon = 0;
    bit pend = 0;
    int pend_val = 0;

    toy_bpu_tage_base_ctrl #(.INDEX_W(4), .CTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .lkp_vld(lkp_vld), .lkp_idx(lkp_idx), .lkp_rdy(lkp_rdy),
        .lkp_rsp_vld(lkp_rsp_vld), .lkp_rsp_ctr(lkp_rsp_ctr), .lkp_rsp_taken(lkp_rsp_taken),
        .upd_vld(upd_vld), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_rdy(upd_rdy),
        .tbl_req_vld(tbl_req_vld), .tbl_req_wren(tbl_req_wren), .tbl_req_addr(tbl_req_addr),
        .tbl_req_wdata(tbl_req_wdata), .tbl_ack_rdata(tbl_ack_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (tbl_req_vld) begin
            if (tbl_req_wren) mem[tbl_req_addr] <= tbl_req_wdata;
            else tbl_ack_rdata <= mem[tbl_req_addr];
        end
    end

    typedef struct { logic lv; logic uv; logic e_lrdy; logic e_urdy; logic e_req; int e_addr; } arb_vec_t;
    typedef struct { int start; logic tk; int expv; } upd_vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_next(input int v, input bit tk);
        if (tk) return (v + 1 > 3) ? 3 : v + 1;
        return (v - 1 < 0) ? 0 : v - 1;
    endfunction

    // Checks the previous cycle's accepted lookup, then records this cycle's handshakes.
    task automatic mon_step();
        if (pend) begin
            chk("rsp_vld", lkp_rsp_vld, 1);
            chk("rsp_ctr", lkp_rsp_ctr, pend_val);
            chk("rsp_taken", lkp_rsp_taken, pend_val / 2);
        end else begin
            chk("rsp_idle", lkp_rsp_vld, 0);
        end
        if (tbl_req_vld && !tbl_req_wren) chk("rd_wdata", tbl_req_wdata, 0);
        pend = lkp_vld && lkp_rdy;
        pend_val = model[lkp_idx];
        if (upd_vld && upd_rdy) model[upd_idx] = sat_next(model[upd_idx], upd_taken);
        if (rst) begin
            pend = 0;
            for (int i = 0; i < 16; i++) model[i] = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon) mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_init();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_vld", tbl_req_vld, 1);
            chk("init_wren", tbl_req_wren, 1);
            chk("init_addr", tbl_req_addr, i);
            chk("init_wdata", tbl_req_wdata, 1);
            chk("init_lkp_rdy", lkp_rdy, 0);
            chk("init_upd_rdy", upd_rdy, 0);
            chk("init_done_lo", init_done, 0);
            tick();
        end
        #1;
        chk("init_done_hi", init_done, 1);
        chk("idle_req_vld", tbl_req_vld, 0);
        chk("idle_lkp_rdy", lkp_rdy, 1);
    endtask

    task automatic do_update(input logic [3:0] idx, input logic tk, output int wd);
        int n = 0;
        upd_idx = idx; upd_taken = tk; upd_vld = 1'b1;
        #1;
        while (!upd_rdy && n < 20) begin tick(); #1; n++; end
        chk("upd_accept", upd_rdy, 1);
        tick();
        upd_vld = 1'b0;
        tick();
        #1;
        chk("upd_wr_wren", tbl_req_wren, 1);
        chk("upd_wr_addr", tbl_req_addr, idx);
        wd = tbl_req_wdata;
        tick();
    endtask

    task automatic do_lookup(input logic [3:0] idx, output int ctr, output int tk);
        lkp_idx = idx; lkp_vld = 1'b1;
        #1;
        chk("lkp_rdy", lkp_rdy, 1);
        tick();
        lkp_vld = 1'b0;
        #1;
        chk("lkp_rsp_next", lkp_rsp_vld, 1);
        ctr = lkp_rsp_ctr;
        tk = lkp_rsp_taken;
        tick();
    endtask

    task automatic poke(input logic [3:0] idx, input logic [1:0] val);
        poke_idx = idx; poke_val = val; poke_en = 1'b1;
        model[idx] = val;
        tick();
        poke_en = 1'b0;
    endtask

    initial begin
        arb_vec_t av [4];
        upd_vec_t uv [8];
        int wd, ctr, tk, fires;

        av[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        av[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        av[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9};
        av[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3};
        uv[0] = '{0, 1'b0, 0}; uv[1] = '{0, 1'b1, 1}; uv[2] = '{1, 1'b1, 2}; uv[3] = '{2, 1'b1, 3};
        uv[4] = '{3, 1'b1, 3}; uv[5] = '{3, 1'b0, 2}; uv[6] = '{1, 1'b0, 0}; uv[7] = '{2, 1'b0, 1};

        for (int i = 0; i < 16; i++) model[i] = 1;
        rst = 1'b1; lkp_vld = 1'b0; upd_vld = 1'b0; lkp_idx = '0; upd_idx = '0; upd_taken = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("rst_req_vld", tbl_req_vld, 0);
        chk("rst_lkp_rdy", lkp_rdy, 0);
        chk("rst_upd_rdy", upd_rdy, 0);
        chk("rst_rsp_vld", lkp_rsp_vld, 0);
        chk("rst_init_done", init_done, 0);
        rst = 1'b0;
        mon = 1;
        run_init();

        // Arbitration in IDLE, starvation counter at zero.
        lkp_idx = 4'd3; upd_idx = 4'd9;
        foreach (av[i]) begin
            lkp_vld = av[i].lv; upd_vld = av[i].uv;
            #1;
            chk("arb_lkp_rdy", lkp_rdy, av[i].e_lrdy);
            chk("arb_upd_rdy", upd_rdy, av[i].e_urdy);
            chk("arb_req_vld", tbl_req_vld, av[i].e_req);
            if (av[i].e_req) begin
                chk("arb_addr", tbl_req_addr, av[i].e_addr);
                chk("arb_wren", tbl_req_wren, 0);
            end
        end
        lkp_vld = 1'b0; upd_vld = 1'b0;
        tick();

        do_update(4'd5, 1'b1, wd); chk("sat_up_1", wd, 2);
        do_update(4'd5, 1'b1, wd); chk("sat_up_2", wd, 3);
        do_update(4'd5, 1'b1, wd); chk("sat_up_3", wd, 3);
        do_lookup(4'd5, ctr, tk);
        chk("sat_up_ctr", ctr, 3); chk("sat_up_taken", tk, 1);

        poke(4'd2, 2'd0);
        do_update(4'd2, 1'b0, wd); chk("sat_dn_wr", wd, 0);
        do_lookup(4'd2, ctr, tk);
        chk("sat_dn_ctr", ctr, 0); chk("sat_dn_taken", tk, 0);

        foreach (uv[i]) begin
            poke(4'd10, 2'(uv[i].start));
            do_update(4'd10, uv[i].tk, wd);
            chk("upd_table", wd, uv[i].expv);
        end

        // Lookup forwarded from the in-flight update, then blocked in WRITE.
        upd_idx = 4'd7; upd_taken = 1'b1; upd_vld = 1'b1;
        #1; chk("fwd_upd_rdy", upd_rdy, 1);
        tick();
        upd_vld = 1'b0; lkp_vld = 1'b1; lkp_idx = 4'd7;
        #1; chk("fwd_lkp_rdy", lkp_rdy, 1);
        tick();
        #1;
        chk("fwd_rsp_vld", lkp_rsp_vld, 1);
        chk("fwd_rsp_ctr", lkp_rsp_ctr, 2);
        chk("write_lkp_rdy", lkp_rdy, 0);
        chk("fwd_wr_addr", tbl_req_addr, 7);
        chk("fwd_wr_data", tbl_req_wdata, 2);
        lkp_vld = 1'b0;
        tick();

        // Continuous lookup pressure: waiting update must win on the fourth cycle.
        fires = 0;
        lkp_vld = 1'b1; lkp_idx = 4'd0; upd_vld = 1'b1; upd_idx = 4'd1; upd_taken = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (upd_rdy) fires++;
            if (c < 4) begin
                chk("starve_lkp_rdy", lkp_rdy, 1);
                chk("starve_upd_rdy", upd_rdy, 0);
            end else if (c == 4) begin
                chk("starve4_lkp_rdy", lkp_rdy, 0);
                chk("starve4_upd_rdy", upd_rdy, 1);
                chk("starve4_addr", tbl_req_addr, 1);
                chk("starve4_wren", tbl_req_wren, 0);
            end
            tick();
        end
        chk("starve_upd_count", fires, 1);
        lkp_vld = 1'b0; upd_vld = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        for (int c = 0; c < 400; c++) begin
            lkp_vld = 1'($urandom_range(0, 1));
            lkp_idx = 4'($urandom_range(0, 3));
            upd_vld = 1'($urandom_range(0, 1));
            upd_idx = 4'($urandom_range(0, 3));
            upd_taken = 1'($urandom_range(0, 1));
            tick();
        end
        lkp_vld = 1'b0; upd_vld = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 16; i++) chk("mem_vs_model", mem[i], model[i]);

        // Reset during RD_WAIT: the pending write must never reach the table.
        upd_idx = 4'd7; upd_taken = 1'b1; upd_vld = 1'b1;
        #1; chk("rmw_rst_upd_rdy", upd_rdy, 1);
        tick();
        upd_vld = 1'b0; rst = 1'b1;
        #1; chk("rmw_rst_req_vld", tbl_req_vld, 0);
        tick();
        #1;
        chk("post_rst_req_vld", tbl_req_vld, 0);
        chk("post_rst_rsp_vld", lkp_rsp_vld, 0);
        chk("post_rst_lkp_rdy", lkp_rdy, 0);
        chk("post_rst_upd_rdy", upd_rdy, 0);
        chk("post_rst_init_done", init_done, 0);
        rst = 1'b0;
        run_init();
        do_lookup(4'd7, ctr, tk);
        chk("post_rst_ctr7", ctr, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
